// File: rtl/hazard_stall_unit.sv
// Decode-stage interlock: stalls IF/ID and bubbles ID/EX for RAW hazards that
// forwarding cannot cover (load-use, and operands compared in ID).
module hazard_stall_unit #(
  parameter int unsigned STALL_W = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        Instr,
  input  logic               ID_Valid,
  input  logic               RegWrite,
  input  logic               RegDest,
  input  logic               Link,
  input  logic               MemRead,
  input  logic               UseRs,
  input  logic               UseRt,
  input  logic               CmpInID,
  input  logic               Freeze,
  output logic               Stall_IF,
  output logic               Stall_ID,
  output logic               Bubble_EX,
  output logic [STALL_W-1:0] StallCnt
);

  logic [4:0]         rs, rt, rd, dest_id;
  logic [4:0]         h0_dest, h1_dest;
  logic               h0_load, h1_load;
  logic [STALL_W-1:0] cnt, cnt_next, n_rs, n_rt, n_req;
  logic               hazard, stall;

  assign rs = Instr[25:21];
  assign rt = Instr[20:16];
  assign rd = Instr[15:11];

  always_comb begin
    dest_id = '0;
    if (ID_Valid && RegWrite) begin
      if (Link)         dest_id = 5'd31;
      else if (RegDest) dest_id = rd;
      else              dest_id = rt;
    end
  end

  // Stall cycles one source needs; r0 never matches, so dest 0 means "no writer".
  function automatic logic [STALL_W-1:0] need(
    input logic       use_src,
    input logic [4:0] src,
    input logic       valid,
    input logic       cmp,
    input logic [4:0] d0,
    input logic       l0,
    input logic [4:0] d1,
    input logic       l1
  );
    logic hit0, hit1;
    need = '0;
    hit0 = valid && use_src && (src != 5'd0) && (src == d0);
    hit1 = valid && use_src && (src != 5'd0) && (src == d1);
    if (cmp) begin
      if (hit0 && l0)                          need = STALL_W'(2);
      else if ((hit0 && !l0) || (hit1 && l1))  need = STALL_W'(1);
    end else begin
      if (hit0 && l0)                          need = STALL_W'(1);
    end
  endfunction

  always_comb begin
    n_rs  = need(UseRs, rs, ID_Valid, CmpInID, h0_dest, h0_load, h1_dest, h1_load);
    n_rt  = need(UseRt, rt, ID_Valid, CmpInID, h0_dest, h0_load, h1_dest, h1_load);
    n_req = (n_rs > n_rt) ? n_rs : n_rt;
  end

  always_comb begin
    hazard   = (cnt == '0) && (n_req != '0);
    stall    = (cnt != '0) || hazard;
    cnt_next = '0;
    if (hazard)           cnt_next = n_req - STALL_W'(1);
    else if (cnt != '0)   cnt_next = cnt - STALL_W'(1);
  end

  assign Stall_IF  = stall;
  assign Stall_ID  = stall;
  assign Bubble_EX = stall;
  assign StallCnt  = cnt_next;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt     <= '0;
      h0_dest <= '0;
      h0_load <= 1'b0;
      h1_dest <= '0;
      h1_load <= 1'b0;
    end else if (!Freeze) begin
      cnt     <= cnt_next;
      h1_dest <= h0_dest;
      h1_load <= h0_load;
      if (stall) begin
        h0_dest <= '0;
        h0_load <= 1'b0;
      end else begin
        h0_dest <= dest_id;
        h0_load <= MemRead && ID_Valid;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: driver pushes expected stall/StallCnt
// per ID cycle into a queue, a negedge monitor pops and compares.
module tb_hazard_stall_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Instr = '0;
  logic        ID_Valid = 1'b0, RegWrite = 1'b0, RegDest = 1'b0, Link = 1'b0;
  logic        MemRead = 1'b0, UseRs = 1'b0, UseRt = 1'b0, CmpInID = 1'b0;
  logic        Freeze = 1'b0;
  logic        Stall_IF, Stall_ID, Bubble_EX;
  logic [1:0]  StallCnt;

  int unsigned total = 0;
  int unsigned passed = 0;

  hazard_stall_unit #(.STALL_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .Instr(Instr), .ID_Valid(ID_Valid),
    .RegWrite(RegWrite), .RegDest(RegDest), .Link(Link), .MemRead(MemRead),
    .UseRs(UseRs), .UseRt(UseRt), .CmpInID(CmpInID), .Freeze(Freeze),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Bubble_EX(Bubble_EX),
    .StallCnt(StallCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic valid, rw, rdst, link, mr, urs, urt, cmp;
  } id_t;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {6'h0, rs, rt, rd, 11'h0};
  endfunction

  function automatic id_t f_alu(input logic [4:0] rd, input logic [4:0] rs,
                                input logic [4:0] rt);
    return '{instr: mk(rs, rt, rd), valid: 1'b1, rw: 1'b1, rdst: 1'b1, link: 1'b0,
             mr: 1'b0, urs: 1'b1, urt: 1'b1, cmp: 1'b0};
  endfunction

  function automatic id_t f_lw(input logic [4:0] rt, input logic [4:0] rs);
    return '{instr: mk(rs, rt, 5'd0), valid: 1'b1, rw: 1'b1, rdst: 1'b0, link: 1'b0,
             mr: 1'b1, urs: 1'b1, urt: 1'b0, cmp: 1'b0};
  endfunction

  function automatic id_t f_beq(input logic [4:0] rs, input logic [4:0] rt);
    return '{instr: mk(rs, rt, 5'd0), valid: 1'b1, rw: 1'b0, rdst: 1'b0, link: 1'b0,
             mr: 1'b0, urs: 1'b1, urt: 1'b1, cmp: 1'b1};
  endfunction

  function automatic id_t f_jal();
    return '{instr: mk(5'd0, 5'd5, 5'd6), valid: 1'b1, rw: 1'b1, rdst: 1'b1, link: 1'b1,
             mr: 1'b0, urs: 1'b0, urt: 1'b0, cmp: 1'b0};
  endfunction

  function automatic id_t f_jr(input logic [4:0] rs);
    return '{instr: mk(rs, 5'd0, 5'd0), valid: 1'b1, rw: 1'b0, rdst: 1'b0, link: 1'b0,
             mr: 1'b0, urs: 1'b1, urt: 1'b0, cmp: 1'b1};
  endfunction

  function automatic id_t f_inv(input id_t v);
    id_t r;
    r = v;
    r.valid = 1'b0;
    return r;
  endfunction

  // One ID cycle: drive just after the rising edge, queue what the monitor must see.
  task automatic issue(input id_t v, input logic frz, input string name,
                       input logic es, input logic [1:0] ec);
    exp_t x;
    @(posedge CLK);
    #1;
    Instr = v.instr; ID_Valid = v.valid; RegWrite = v.rw; RegDest = v.rdst;
    Link = v.link; MemRead = v.mr; UseRs = v.urs; UseRt = v.urt; CmpInID = v.cmp;
    Freeze = frz;
    x.name = name; x.stall = es; x.cnt = ec;
    exp_q.push_back(x);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({Stall_IF, Stall_ID, Bubble_EX} === {3{e.stall}}) passed++;
      else $display("FAIL %s stall: got %b%b%b want %b", e.name,
                    Stall_IF, Stall_ID, Bubble_EX, e.stall);
      total++;
      if (StallCnt === e.cnt) passed++;
      else $display("FAIL %s StallCnt: got %0d want %0d", e.name, StallCnt, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    id_t nop;
    nop = f_inv(f_alu(5'd1, 5'd1, 5'd1));

    issue(f_beq(5'd3, 5'd3), 1'b0, "rst_state", 1'b0, 2'd0);
    RESET = 1'b1;
    issue(nop, 1'b0, "idle", 1'b0, 2'd0);

    // load-use into ALU; the branch then proves H0 took {6,0} on release
    issue(f_lw(5'd5, 5'd1),        1'b0, "lu_lw",       1'b0, 2'd0);
    issue(f_alu(5'd6, 5'd5, 5'd1), 1'b0, "lu_stall",    1'b1, 2'd0);
    issue(f_alu(5'd6, 5'd5, 5'd1), 1'b0, "lu_release",  1'b0, 2'd0);
    issue(f_beq(5'd6, 5'd0),       1'b0, "lu_h0_alu",   1'b1, 2'd0);
    issue(f_beq(5'd6, 5'd0),       1'b0, "lu_h0_rel",   1'b0, 2'd0);

    // branch after ALU, then after a load
    issue(f_alu(5'd3, 5'd1, 5'd2), 1'b0, "ba_add",      1'b0, 2'd0);
    issue(f_beq(5'd3, 5'd4),       1'b0, "ba_stall",    1'b1, 2'd0);
    issue(f_beq(5'd3, 5'd4),       1'b0, "ba_release",  1'b0, 2'd0);
    issue(f_lw(5'd3, 5'd1),        1'b0, "bl_lw",       1'b0, 2'd0);
    issue(f_beq(5'd3, 5'd4),       1'b0, "bl_stall1",   1'b1, 2'd1);
    issue(f_beq(5'd3, 5'd4),       1'b0, "bl_stall2",   1'b1, 2'd0);
    issue(f_beq(5'd3, 5'd4),       1'b0, "bl_release",  1'b0, 2'd0);

    // branch two after a load vs. two after an ALU writer
    issue(f_lw(5'd7, 5'd1),        1'b0, "b2_lw",       1'b0, 2'd0);
    issue(f_alu(5'd8, 5'd1, 5'd2), 1'b0, "b2_gap",      1'b0, 2'd0);
    issue(f_beq(5'd7, 5'd0),       1'b0, "b2_mem_ld",   1'b1, 2'd0);
    issue(f_beq(5'd7, 5'd0),       1'b0, "b2_release",  1'b0, 2'd0);
    issue(f_alu(5'd7, 5'd1, 5'd2), 1'b0, "b2a_add",     1'b0, 2'd0);
    issue(f_alu(5'd8, 5'd1, 5'd2), 1'b0, "b2a_gap",     1'b0, 2'd0);
    issue(f_beq(5'd7, 5'd0),       1'b0, "b2a_nostall", 1'b0, 2'd0);

    // r0 destination never matches
    issue(f_lw(5'd0, 5'd1),        1'b0, "r0_lw",       1'b0, 2'd0);
    issue(f_alu(5'd6, 5'd0, 5'd0), 1'b0, "r0_use",      1'b0, 2'd0);

    // invalid slot never stalls and pushes an empty entry
    issue(f_lw(5'd9, 5'd1),             1'b0, "inv_lw",    1'b0, 2'd0);
    issue(f_inv(f_beq(5'd9, 5'd9)),     1'b0, "inv_match", 1'b0, 2'd0);
    issue(f_beq(5'd9, 5'd0),            1'b0, "inv_aged",  1'b1, 2'd0);
    issue(f_beq(5'd9, 5'd0),            1'b0, "inv_rel",   1'b0, 2'd0);

    // link writes r31
    issue(f_jal(),      1'b0, "jal",        1'b0, 2'd0);
    issue(f_jr(5'd31),  1'b0, "jr_stall",   1'b1, 2'd0);
    issue(f_jr(5'd31),  1'b0, "jr_release", 1'b0, 2'd0);

    // rs needs 2, rt needs 1: max wins, not the sum
    issue(f_lw(5'd4, 5'd1),  1'b0, "mx_lw4",   1'b0, 2'd0);
    issue(f_lw(5'd5, 5'd1),  1'b0, "mx_lw5",   1'b0, 2'd0);
    issue(f_beq(5'd5, 5'd4), 1'b0, "mx_st1",   1'b1, 2'd1);
    issue(f_beq(5'd5, 5'd4), 1'b0, "mx_st2",   1'b1, 2'd0);
    issue(f_beq(5'd5, 5'd4), 1'b0, "mx_rel",   1'b0, 2'd0);

    // load with dest == own src
    issue(f_lw(5'd5, 5'd5),  1'b0, "self_lw",  1'b0, 2'd0);
    issue(nop,               1'b0, "self_nop", 1'b0, 2'd0);
    issue(nop,               1'b0, "self_nop2",1'b0, 2'd0);

    // freeze mid-stall (Cnt=1): 2 + 3 stall cycles in total
    issue(f_lw(5'd3, 5'd1),  1'b0, "fz_lw",    1'b0, 2'd0);
    issue(f_beq(5'd3, 5'd4), 1'b0, "fz_st1",   1'b1, 2'd1);
    for (int i = 0; i < 3; i++)
      issue(f_beq(5'd3, 5'd4), 1'b1, "fz_hold", 1'b1, 2'd0);
    issue(f_beq(5'd3, 5'd4), 1'b0, "fz_st2",   1'b1, 2'd0);
    issue(f_beq(5'd3, 5'd4), 1'b0, "fz_rel",   1'b0, 2'd0);

    // freeze on the hazard cycle itself: history and Cnt must not age
    issue(f_lw(5'd3, 5'd1),  1'b0, "fh_lw",    1'b0, 2'd0);
    for (int i = 0; i < 3; i++)
      issue(f_beq(5'd3, 5'd4), 1'b1, "fh_hold", 1'b1, 2'd1);
    issue(f_beq(5'd3, 5'd4), 1'b0, "fh_st1",   1'b1, 2'd1);
    issue(f_beq(5'd3, 5'd4), 1'b0, "fh_st2",   1'b1, 2'd0);
    issue(f_beq(5'd3, 5'd4), 1'b0, "fh_rel",   1'b0, 2'd0);

    // async reset while Cnt=1 with a load still in H1
    issue(f_lw(5'd3, 5'd1),  1'b0, "rm_lw",    1'b0, 2'd0);
    issue(f_beq(5'd3, 5'd4), 1'b0, "rm_st1",   1'b1, 2'd1);
    issue(f_beq(5'd3, 5'd4), 1'b0, "rm_low",   1'b0, 2'd0);
    #1 RESET = 1'b0;
    issue(f_beq(5'd3, 5'd4), 1'b0, "rm_stale", 1'b0, 2'd0);
    #1 RESET = 1'b1;
    issue(f_beq(5'd3, 5'd4), 1'b0, "rm_after", 1'b0, 2'd0);
    issue(f_alu(5'd6, 5'd3, 5'd4), 1'b0, "rm_next", 1'b0, 2'd0);

    @(posedge CLK);
    @(posedge CLK);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-stage interlock that sits directly upstream of the forwarding logic. It inspects the instruction in ID against a two-deep history of in-flight destination registers. It stalls IF/ID and injects a bubble into ID/EX for any RAW hazard that forwarding cannot cover: load-use, and compare-in-ID consumers such as branches and jr. While a bubble is injected, the forwarding logic sees RegWrite=0, so its own history stays consistent.

## Interface
- `STALL_W`, default 2: width of the stall down-counter (max 3 stall cycles).
- `CLK` in 1: system clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `Instr` in 32: instruction in ID. rs=[25:21], rt=[20:16], rd=[15:11].
- `ID_Valid` in 1: the ID instruction is real (0 = squashed or empty).
- `RegWrite` in 1: the ID instruction writes a register.
- `RegDest` in 1: destination is rd (else rt).
- `Link` in 1: destination is r31 (overrides RegDest).
- `MemRead` in 1: the ID instruction is a load.
- `UseRs` in 1: the ID instruction reads rs.
- `UseRt` in 1: the ID instruction reads rt (ALU operand or store data).
- `CmpInID` in 1: rs/rt are consumed in ID (branch compare, jr/jalr).
- `Freeze` in 1: global pipeline hold (memory busy); all state holds.
- `Stall_IF` out 1: hold the PC.
- `Stall_ID` out 1: hold the IF/ID register.
- `Bubble_EX` out 1: load a NOP into ID/EX (RegWrite/MemWrite/MemRead forced 0).
- `StallCnt` out STALL_W: remaining stall cycles after the current one (debug).

## Operation
- **Destination of the ID instruction:**
  - `DestID` = 0 if !ID_Valid or !RegWrite.
  - Otherwise 31 if Link, else rd if RegDest, else rt.
- **History registers:** `H0` (EX stage) and `H1` (MEM stage), each holding {dest[4:0], isLoad}. Dest 0 means no hazard; r0 never matches.
- **Match terms,** for src in {rs if UseRs, rt if UseRt}, evaluated only when ID_Valid:
  - `mEXL`: src == H0.dest and H0.isLoad.
  - `mEXA`: src == H0.dest and !H0.isLoad.
  - `mMEML`: src == H1.dest and H1.isLoad.
- **Required stall cycles N:**
  - CmpInID: mEXL→2; else mEXA or mMEML→1; else 0.
  - Not CmpInID: mEXL→1; else 0.
  - N is the maximum over both sources.
- **Counter:** `Cnt`, STALL_W bits.
  - `Hazard` = (Cnt==0) and (N≠0).
  - `Stall` = (Cnt≠0) or Hazard.
  - Stall_IF = Stall_ID = Bubble_EX = Stall. Combinational (Mealy), valid in the same cycle the instruction is in ID.
- **Clock edge, Freeze=0:**
  - If Hazard: Cnt ← N−1. Else if Cnt≠0: Cnt ← Cnt−1.
  - H1 ← H0.
  - H0 ← Stall ? {0,0} : {DestID, MemRead & ID_Valid}.
- **Clock edge, Freeze=1:** Cnt, H0 and H1 all hold. Outputs keep following the combinational equations.
- **While Cnt≠0:** no re-evaluation. The stalled instruction is released when Cnt reaches 0 and N recomputes to 0. The bubbles have aged the history, so it must recompute to 0; the bench must flag it if it does not.
- **Reset** (async, any time including mid-stall): Cnt=0, H0=H1={0,0}. Stall_IF/Stall_ID/Bubble_EX=0 and StallCnt=0 while RESET low and history empty.

## Timing
- Zero-latency detection: Stall asserts in the same cycle the dependent instruction occupies ID.
- Stall duration is exactly N consecutive cycles (Freeze cycles excluded).
- Bubbles inserted equal N, and H0 receives exactly N zero entries.
- Release: the first cycle with Stall=0 latches the instruction's DestID into H0 at the following edge.
- Back-to-back hazards: the stalled instruction's own destination only enters H0 on release, so the next instruction is evaluated normally.
- ID_Valid=0 never stalls and pushes {0,0}.
- Simultaneous rs and rt hazards: the larger N wins, with no additive stalls.
- A load whose dest equals its own src does not self-stall; only older history is compared.

## Test plan
- **Load-use ALU:** lw r5 then add r6,r5,r1 → Stall=1 for 1 cycle, one bubble, H0 sequence {5,1},{0,0},{6,0}.
- **Branch after ALU:** add r3 then beq r3,r4 → 1 stall cycle. Branch after lw r3 → 2 stall cycles, StallCnt shows 1 then 0.
- **Branch two after a load:** lw r7; unrelated; beq r7,r0 → 1 stall. Same sequence with non-load writer → 0 stalls.
- **r0, invalid and Link:**
  - lw r0 then use r0 → no stall.
  - ID_Valid=0 with matching fields → no stall.
  - jal (Link) then jr r31 → 1 stall.
- **Freeze during a 2-cycle stall:** Freeze high 3 cycles mid-stall → Cnt, H0 and H1 hold. Total Stall-high cycles = 2 + 3, then release.
- **Reset mid-stall:** RESET low during Cnt=1 → outputs 0 immediately, Cnt=0, history cleared. After RESET high, the next instruction sees no stale hazard.
